// File: rtl/enc_cond_pkg.sv
// Shared types and default parameter values for the encoder input conditioner.
//
// Contents:
//   deb_state_t       - per-line debounce FSM state
//   DEF_NUM_LINES     - default number of conditioned lines
//   DEF_SYNC_STAGES   - default synchroniser depth
//   DEF_PRESCALE      - default clk cycles per sample tick
//   DEF_DEBOUNCE_CNT  - default consecutive ticks needed to accept a new level
package enc_cond_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    localparam int DEF_NUM_LINES    = 6;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_PRESCALE     = 64;
    localparam int DEF_DEBOUNCE_CNT = 4;

endpackage

// File: rtl/enc_debounce_line.sv
// One conditioned encoder line: synchroniser, debounce FSM with tick counter,
// registered clean level and optional one-cycle edge strobes.
//
// Build option: ENC_COND_EDGES_EN builds the rise/fall strobe registers;
// without it rise and fall are tied to 0.
//
// Ports:
//   clk    in  - clock, rising edge
//   rst_n  in  - synchronous active-low reset
//   raw    in  - asynchronous pin
//   tick   in  - shared sample tick (combinational, from the prescaler)
//   clean  out - debounced level, registered
//   rise   out - one-cycle strobe on clean 0->1
//   fall   out - one-cycle strobe on clean 1->0
//
// state   | meaning
// --------+-------------------------------------------------------------
// STABLE  | synchronised input agrees with clean, counter parked at 0
// PENDING | input differs from clean, counting mismatching ticks
module enc_debounce_line
    import enc_cond_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CNT + 1);
    // Counter value at which the next mismatching tick completes the debounce.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   mismatch;
    logic                   accept;
    deb_state_t             state_q;
    deb_state_t             state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   clean_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != clean);
    // The counter is 0 whenever the FSM is STABLE, so one compare covers both
    // the first tick out of STABLE (DEBOUNCE_CNT = 1) and later PENDING ticks.
    assign accept   = mismatch && tick && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            clean   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean   <= clean_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (mismatch && !accept) begin
                    state_d = PENDING;
                    cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
                end
            end
            PENDING: begin
                if (!mismatch || accept) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef ENC_COND_EDGES_EN
    logic rise_d;
    logic fall_d;

    // Output logic
    always_comb begin
        clean_d = accept ? s : clean;
        rise_d  = accept && s;
        fall_d  = accept && !s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= rise_d;
            fall <= fall_d;
        end
    end
`else
    // Output logic
    always_comb begin
        clean_d = accept ? s : clean;
    end

    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/enc_input_conditioner.sv
// Input conditioning for the RGB mixer's rotary encoders: per-line two-flop
// (or deeper) synchroniser and tick-based debounce, sharing one prescaler.
//
// Build option: ENC_COND_EDGES_EN enables the rise_out/fall_out strobes;
// without it they are constant 0 and clean_out timing is unchanged.
//
// Ports:
//   clk        in  - clock, rising edge
//   rst_n      in  - synchronous active-low reset
//   raw_in     in  - [NUM_LINES] asynchronous encoder pins
//   clean_out  out - [NUM_LINES] debounced levels, registered
//   rise_out   out - [NUM_LINES] one-cycle strobe on clean 0->1
//   fall_out   out - [NUM_LINES] one-cycle strobe on clean 1->0
//   tick_out   out - prescaler tick delayed by one cycle, for observation
module enc_input_conditioner
    import enc_cond_pkg::*;
#(
    parameter int NUM_LINES    = DEF_NUM_LINES,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] raw_in,
    output logic [NUM_LINES-1:0] clean_out,
    output logic [NUM_LINES-1:0] rise_out,
    output logic [NUM_LINES-1:0] fall_out,
    output logic                 tick_out
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    // With PRESCALE = 1 the counter sits at 0 = PRE_LAST, so tick stays high.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            tick_out <= 1'b0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
            tick_out <= tick;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        enc_debounce_line #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_line (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_in[i]),
            .tick (tick),
            .clean(clean_out[i]),
            .rise (rise_out[i]),
            .fall (fall_out[i])
        );
    end

endmodule

// File: tb/tb_enc_input_conditioner.sv
// Bench for enc_input_conditioner at PRESCALE=4, DEBOUNCE_CNT=3, SYNC_STAGES=2.
// A behavioural model (delay line + "consecutive mismatching ticks" count per
// line) is stepped on every clock edge and compared on every falling edge.
module tb_enc_input_conditioner;

    localparam int NL = 6;
    localparam int SS = 2;
    localparam int PS = 4;
    localparam int DC = 3;
`ifdef ENC_COND_EDGES_EN
    localparam bit EDGES = 1'b1;
`else
    localparam bit EDGES = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] raw_in;
    logic [NL-1:0] clean_out;
    logic [NL-1:0] rise_out;
    logic [NL-1:0] fall_out;
    logic          tick_out;

    enc_input_conditioner #(
        .NUM_LINES   (NL),
        .SYNC_STAGES (SS),
        .PRESCALE    (PS),
        .DEBOUNCE_CNT(DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (raw_in),
        .clean_out(clean_out),
        .rise_out (rise_out),
        .fall_out (fall_out),
        .tick_out (tick_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;

    // reference model state
    logic [NL-1:0] m_clean = '0;
    logic [NL-1:0] m_rise = '0;
    logic [NL-1:0] m_fall = '0;
    logic          m_tick_out = 1'b0;
    logic [NL-1:0] m_pipe [SS];
    int            m_phase = 0;
    int            m_run [NL];

    int rcnt [NL];
    int fcnt [NL];

    typedef struct {
        logic          rst;
        logic [NL-1:0] raw;
        int            cycles;
        logic [NL-1:0] exp_clean;
        logic [NL-1:0] exp_rise;
        logic [NL-1:0] exp_fall;
    } vec_t;

    vec_t tbl [8];

    function automatic void model_step();
        logic [NL-1:0] s_vec;
        logic          tk;
        if (!rst_n) begin
            m_clean    = '0;
            m_rise     = '0;
            m_fall     = '0;
            m_tick_out = 1'b0;
            m_phase    = 0;
            for (int j = 0; j < SS; j++) m_pipe[j] = '0;
            for (int i = 0; i < NL; i++) m_run[i] = 0;
        end else begin
            s_vec      = m_pipe[SS-1];
            tk         = (m_phase == PS - 1);
            m_phase    = (m_phase + 1) % PS;
            m_tick_out = tk;
            m_rise     = '0;
            m_fall     = '0;
            for (int i = 0; i < NL; i++) begin
                if (s_vec[i] == m_clean[i]) begin
                    m_run[i] = 0;
                end else if (tk) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DC) begin
                        m_clean[i] = s_vec[i];
                        m_run[i]   = 0;
                        if (EDGES) begin
                            if (s_vec[i]) m_rise[i] = 1'b1;
                            else          m_fall[i] = 1'b1;
                        end
                    end
                end
            end
            for (int j = SS - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = raw_in;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        tests++;
        if (clean_out !== m_clean || rise_out !== m_rise ||
            fall_out !== m_fall || tick_out !== m_tick_out) begin
            fails++;
            $display("FAIL model cyc %0d: got clean=%h rise=%h fall=%h tick=%b, want clean=%h rise=%h fall=%h tick=%b",
                     cyc_no, clean_out, rise_out, fall_out, tick_out,
                     m_clean, m_rise, m_fall, m_tick_out);
        end
        for (int i = 0; i < NL; i++) begin
            if (rise_out[i] === 1'b1) rcnt[i]++;
            if (fall_out[i] === 1'b1) fcnt[i]++;
        end
        cyc_no++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NL; i++) begin
            rcnt[i] = 0;
            fcnt[i] = 0;
        end
    endtask

    function automatic logic [4*NL-1:0] pack_cnt(input int c [NL]);
        logic [4*NL-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[4*i +: 4] = 4'((c[i] > 15) ? 15 : c[i]);
        return v;
    endfunction

    function automatic logic [4*NL-1:0] pack_mask(input logic [NL-1:0] m);
        logic [4*NL-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[4*i +: 4] = {3'b000, m[i] & EDGES};
        return v;
    endfunction

    task automatic check_vec(input string name, input logic [NL-1:0] got,
                             input logic [NL-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_pulses(input string name, input logic [NL-1:0] rmask,
                                input logic [NL-1:0] fmask);
        tests++;
        if (pack_cnt(rcnt) !== pack_mask(rmask)) begin
            fails++;
            $display("FAIL %s rise counts: got %h, want %h", name, pack_cnt(rcnt), pack_mask(rmask));
        end
        tests++;
        if (pack_cnt(fcnt) !== pack_mask(fmask)) begin
            fails++;
            $display("FAIL %s fall counts: got %h, want %h", name, pack_cnt(fcnt), pack_mask(fmask));
        end
    endtask

    initial begin
        int c1, c5, r1, f5, exp_s;
        int rate;
        logic [NL-1:0] nxt;

        rst_n  = 1'b0;
        raw_in = '0;
        for (int j = 0; j < SS; j++) m_pipe[j] = '0;
        for (int i = 0; i < NL; i++) m_run[i] = 0;
        clear_counts();

        //          rst   raw     cyc  clean   rise    fall
        tbl[0] = '{1'b0, 6'h3F,  3, 6'h00, 6'h00, 6'h00};  // held high in reset
        tbl[1] = '{1'b1, 6'h3F, 16, 6'h3F, 6'h3F, 6'h00};  // full debounce after release
        tbl[2] = '{1'b1, 6'h00, 16, 6'h00, 6'h00, 6'h3F};
        tbl[3] = '{1'b1, 6'h01, 16, 6'h01, 6'h01, 6'h00};  // clean step on line 0
        tbl[4] = '{1'b1, 6'h05,  8, 6'h01, 6'h00, 6'h00};  // line 2 glitch, 2 ticks
        tbl[5] = '{1'b1, 6'h01, 16, 6'h01, 6'h00, 6'h00};
        tbl[6] = '{1'b1, 6'h21, 16, 6'h21, 6'h20, 6'h00};  // line 5 debounced high
        tbl[7] = '{1'b1, 6'h21,  4, 6'h21, 6'h00, 6'h00};  // quiet hold

        for (int v = 0; v < 8; v++) begin
            rst_n  = tbl[v].rst;
            raw_in = tbl[v].raw;
            clear_counts();
            for (int k = 0; k < tbl[v].cycles; k++) cyc();
            check_vec($sformatf("vec%0d clean", v), clean_out, tbl[v].exp_clean);
            check_pulses($sformatf("vec%0d", v), tbl[v].exp_rise, tbl[v].exp_fall);
            if (v == 0) begin
                tests++;
                if (tick_out !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_tick: got %b, want 0", tick_out);
                end
            end
        end

        // simultaneous: line 1 rises and line 5 falls on the same edge
        clear_counts();
        raw_in = 6'h03;
        c1 = -1; c5 = -1; r1 = -1; f5 = -1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            if (c1 < 0 && clean_out[1] === 1'b1) c1 = k;
            if (c5 < 0 && clean_out[5] === 1'b0) c5 = k;
            if (r1 < 0 && rise_out[1] === 1'b1) r1 = k;
            if (f5 < 0 && fall_out[5] === 1'b1) f5 = k;
        end
        tests++;
        if (c1 < 0 || c1 != c5) begin
            fails++;
            $display("FAIL simul_clean: line1 at %0d, line5 at %0d, want equal and >= 0", c1, c5);
        end
        exp_s = EDGES ? c1 : -1;
        tests++;
        if (r1 != exp_s || f5 != exp_s) begin
            fails++;
            $display("FAIL simul_strobe: rise1 at %0d, fall5 at %0d, want both %0d", r1, f5, exp_s);
        end
        check_vec("simul_final", clean_out, 6'h03);

        // bounce on line 4: 3-cycle segments never reach 3 ticks
        clear_counts();
        for (int t = 0; t < 10; t++) begin
            raw_in[4] = ~raw_in[4];
            repeat (3) cyc();
        end
        raw_in[4] = 1'b1;
        repeat (16) cyc();
        check_vec("bounce_clean", clean_out, 6'h13);
        check_pulses("bounce", 6'h10, 6'h00);

        // reset in the middle of a debounce on line 3
        raw_in = 6'h1B;
        repeat (10) cyc();
        check_vec("mid_pre_reset", clean_out, 6'h13);
        rst_n = 1'b0;
        repeat (2) cyc();
        check_vec("mid_in_reset", clean_out, 6'h00);
        rst_n = 1'b1;
        clear_counts();
        repeat (11) cyc();
        check_vec("mid_full_debounce", clean_out, 6'h00);
        repeat (5) cyc();
        check_vec("mid_after", clean_out, 6'h1B);
        check_pulses("mid_after", 6'h1B, 6'h00);

        // randomized phase against the model, with slow/fast toggling and rare resets
        for (int k = 0; k < 3000; k++) begin
            rate = (((k / 500) % 2) != 0) ? 4 : 40;
            nxt  = raw_in;
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, rate - 1) == 0) nxt[i] = ~nxt[i];
            end
            raw_in = nxt;
            rst_n  = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enc_input_conditioner.md
# enc_input_conditioner

Input conditioning stage in front of the RGB mixer's rotary-encoder inputs. It takes the six raw encoder pins (three encoders, A/B each) and applies a two-flop synchroniser, a shared sample-tick prescaler and a per-line debounce filter. It drives clean, glitch-free levels into the mixer's `enc*_a`/`enc*_b` inputs, plus optional single-cycle edge strobes.

## Interface
Parameters:
- `NUM_LINES`, default 6: number of conditioned lines; line i maps to ui_in[i].
- `SYNC_STAGES`, default 2: synchroniser depth; must be ≥ 2.
- `PRESCALE`, default 64: clk cycles per sample tick; must be ≥ 1 (1 = tick every cycle).
- `DEBOUNCE_CNT`, default 4: consecutive mismatching ticks required to accept a new level; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `raw_in`, in, NUM_LINES: asynchronous encoder pins.
- `clean_out`, out, NUM_LINES: debounced levels, registered.
- `rise_out`, out, NUM_LINES: one-cycle strobe when the matching clean_out goes 0→1.
- `fall_out`, out, NUM_LINES: one-cycle strobe when the matching clean_out goes 1→0.
- `tick_out`, out, 1: prescaler tick, one cycle wide, exported for test and observation.

## Operation
- Reset: when rst_n is low at a clock edge, the following registers clear to 0 on that edge:
  - all synchroniser flops, the prescaler counter and every line counter;
  - clean_out, rise_out, fall_out and tick_out.
  - Every line FSM goes to STABLE.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops; the last stage is `s[i]`.
- Prescaler:
  - Counter runs 0..PRESCALE-1 and wraps to 0.
  - `tick` is combinational and equals (count == PRESCALE-1).
  - `tick_out` is tick registered, so it lags tick by one cycle.
  - When PRESCALE = 1, tick is constantly high.
- Per-line FSM, with counter width $clog2(DEBOUNCE_CNT+1):
  - STABLE: while s == clean, the counter holds at 0. If s != clean, go to PENDING. If tick is also high in that cycle, count that tick (counter ← 1).
  - PENDING, s == clean (bounce back): counter ← 0 and return to STABLE. This happens on any cycle, not only tick cycles.
  - PENDING, s != clean, tick high: counter increments. When the incremented value would equal DEBOUNCE_CNT:
    - clean ← s;
    - counter ← 0;
    - state ← STABLE;
    - on the same edge, rise_out or fall_out ← 1 according to direction.
  - In every other cycle, rise_out and fall_out are 0.
  - With DEBOUNCE_CNT = 1, the first tick that observes a mismatch flips clean.
- Lines are fully independent; simultaneous changes on several lines all resolve on the same tick.
- Reset mid-debounce discards partial counts. A line held high through reset needs a full debounce after release, and then produces a rise strobe.

## Timing
- Take raw_in changing before edge k.
- s reflects the change at edge k+SYNC_STAGES-1.
- With PRESCALE = 1, clean_out and the strobe update at edge k+SYNC_STAGES-1+DEBOUNCE_CNT.
- Worst-case latency: (SYNC_STAGES-1) + PRESCALE·DEBOUNCE_CNT cycles.
- Minimum accepted pulse width: at least DEBOUNCE_CNT consecutive ticks. Shorter pulses are fully rejected and produce no strobe.
- Strobes are exactly one cycle wide and never assert twice for one transition.

## Configuration
- Macro: `ENC_COND_EDGES_EN`.
- Defined: rise_out and fall_out behave as above.
- Undefined:
  - rise_out and fall_out are tied to 0;
  - the strobe registers are not built;
  - clean_out timing is unchanged.

## Structure
- Package `enc_cond_pkg` holds:
  - `deb_state_t` enum {STABLE, PENDING};
  - default parameter constants: NUM_LINES, SYNC_STAGES, PRESCALE, DEBOUNCE_CNT.
- Sub-module `enc_debounce_line`: one synchroniser + FSM + counter + strobe logic, instantiated NUM_LINES times through generate.
- The prescaler lives in the top module and is shared by all lines.

## Test plan
Unless stated otherwise, the bench runs PRESCALE=4, DEBOUNCE_CNT=3, SYNC_STAGES=2.
- Reset: drive raw_in=6'h3F while rst_n is low for 3 cycles -> clean_out=0, strobes=0, tick_out=0. After release, clean_out=6'h3F within 1+12 cycles and rise_out=6'h3F for exactly one cycle.
- Clean step: set raw_in[0] 0→1 and hold -> clean_out[0]=1 after at most 13 cycles, single rise_out[0] pulse, other lines unchanged.
- Glitch rejection: pulse raw_in[2] high for 8 cycles (2 ticks), then low -> clean_out[2] stays 0, no strobe.
- Bounce: toggle raw_in[4] every 3 cycles for 30 cycles, then hold 1 -> exactly one rise_out[4] pulse, no fall_out[4].
- Simultaneous: flip raw_in[1] and raw_in[5] on the same cycle, with raw_in[5] going 1→0 from a debounced-high state -> both clean_out bits update on the same edge, with rise_out[1] and fall_out[5] asserted together.
- Reset mid-debounce: start a 0→1 on raw_in[3] and assert rst_n after 2 ticks -> clean_out[3]=0. After release, a full 3-tick debounce is required. With ENC_COND_EDGES_EN undefined, rise_out and fall_out stay 0 throughout.
